apb_reg_dec: RTL and testbench

Parametrised APB slave front-end with wait-state control, the successor to the combinational APB address decoder in the SPI subsystem. It tracks the APB setup/access phases and decodes a based, word-aligned byte address into a one-hot register index. It issues single-cycle write/read strobes to the register file, drives PREADY with a configurable number of wait states, and flags errors on PSLVERR. It sits between the APB interconnect and the SPI control/status register bank.

---
 rtl/apb_dec_pkg.sv | 24 ++
 rtl/apb_addr_match.sv | 47 ++++
 rtl/apb_reg_dec.sv | 161 ++++++++++++++++
 tb/tb_apb_reg_dec.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_dec_pkg.sv
// Shared types and constants for the APB register decoder family.
package apb_dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_state_e;

  localparam int unsigned ERR_CNT_W = 8;
  localparam int unsigned CNT_W     = 4;

  // Bit positions of the individual error causes inside the cause vector
  localparam int unsigned ERR_C_BASE  = 0;
  localparam int unsigned ERR_C_ALIGN = 1;
  localparam int unsigned ERR_C_RANGE = 2;
  localparam int unsigned ERR_C_RO    = 3;
  localparam int unsigned ERR_C_W     = 4;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_match.sv
// Combinational address match: based, word-aligned byte address to register
// index plus a single error flag covering range, alignment and write-protect.
module apb_addr_match
  import apb_dec_pkg::*;
#(
  parameter int unsigned     AWIDTH  = 8,
  parameter int unsigned     REGN    = 8,
  parameter int unsigned     BASE    = 0,
  parameter logic [REGN-1:0] RO_MASK = '0,
  localparam int unsigned    IDXW    = idx_w(REGN)
) (
  input  logic [AWIDTH-1:0] i_paddr,
  input  logic              i_pwrite,
  output logic [IDXW-1:0]   o_index,
  output logic              o_err
);

  localparam int unsigned FW = AWIDTH - 2;

  logic [AWIDTH:0]      w_diff;
  logic [FW-1:0]        w_idx_full;
  logic                 w_ro;
  logic [ERR_C_W-1:0]   w_cause;

  // Extra MSB turns an address below BASE into a visible borrow
  assign w_diff     = {1'b0, i_paddr} - {1'b0, AWIDTH'(BASE)};
  assign w_idx_full = w_diff[AWIDTH-1:2];

  always_comb begin
    w_ro = 1'b0;
    for (int unsigned i = 0; i < REGN; i++) begin
      if (32'(w_idx_full) == i) w_ro = RO_MASK[i];
    end
  end

  always_comb begin
    w_cause              = '0;
    w_cause[ERR_C_BASE]  = w_diff[AWIDTH];
    w_cause[ERR_C_ALIGN] = |w_diff[1:0];
    w_cause[ERR_C_RANGE] = (32'(w_idx_full) >= REGN);
    w_cause[ERR_C_RO]    = i_pwrite & w_ro;
  end

  assign o_err   = |w_cause;
  assign o_index = w_idx_full[IDXW-1:0];

endmodule

// File: rtl/apb_reg_dec.sv
// APB slave front-end: setup/access tracking with wait states, one-hot
// register strobes, PSLVERR generation and a saturating error counter.
module apb_reg_dec
  import apb_dec_pkg::*;
#(
  parameter int unsigned     AWIDTH      = 8,
  parameter int unsigned     DWIDTH      = 32,
  parameter int unsigned     REGN        = 8,
  parameter int unsigned     BASE        = 0,
  parameter int unsigned     WAIT_CYCLES = 0,
  parameter logic [REGN-1:0] RO_MASK     = '0
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic [AWIDTH-1:0]      PADDR,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [DWIDTH-1:0]      PWDATA,
  output logic [DWIDTH-1:0]      PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR,
  output logic [REGN-1:0]        reg_wr_en,
  output logic [REGN-1:0]        reg_rd_en,
  output logic [DWIDTH-1:0]      reg_wdata,
  input  logic [REGN*DWIDTH-1:0] reg_rdata,
  input  logic                   err_clr,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  localparam int unsigned IDXW = idx_w(REGN);

  apb_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                  r_write, w_write_nxt;
  logic [DWIDTH-1:0]     r_wdata, w_wdata_nxt;
  logic [IDXW-1:0]       r_index, w_index_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_pready, w_pready_nxt;
  logic [REGN-1:0]       r_wr_en, w_wr_en_nxt;
  logic [REGN-1:0]       r_rd_en, w_rd_en_nxt;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic [IDXW-1:0]       w_match_idx;
  logic                  w_match_err;
  logic [DWIDTH-1:0]     w_prdata;

  apb_addr_match #(
    .AWIDTH  (AWIDTH),
    .REGN    (REGN),
    .BASE    (BASE),
    .RO_MASK (RO_MASK)
  ) u_match (
    .i_paddr  (PADDR),
    .i_pwrite (PWRITE),
    .o_index  (w_match_idx),
    .o_err    (w_match_err)
  );

  // Next state, transfer latches and the strobes that go live with PREADY
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_write_nxt  = r_write;
    w_wdata_nxt  = r_wdata;
    w_index_nxt  = r_index;
    w_err_nxt    = r_err;
    w_pready_nxt = 1'b0;
    w_wr_en_nxt  = '0;
    w_rd_en_nxt  = '0;

    case (r_state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          w_write_nxt = PWRITE;
          w_wdata_nxt = PWDATA;
          w_index_nxt = w_match_idx;
          w_err_nxt   = w_match_err;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == '0) begin
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    w_pready_nxt = (w_state_nxt == RESP);
    for (int unsigned i = 0; i < REGN; i++) begin
      if (w_pready_nxt && !w_err_nxt && (w_index_nxt == IDXW'(i))) begin
        w_wr_en_nxt[i] = w_write_nxt;
        w_rd_en_nxt[i] = !w_write_nxt;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_index  <= '0;
      r_err    <= 1'b0;
      r_pready <= 1'b0;
      r_wr_en  <= '0;
      r_rd_en  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_write  <= w_write_nxt;
      r_wdata  <= w_wdata_nxt;
      r_index  <= w_index_nxt;
      r_err    <= w_err_nxt;
      r_pready <= w_pready_nxt;
      r_wr_en  <= w_wr_en_nxt;
      r_rd_en  <= w_rd_en_nxt;
    end
  end

  // Error counter: clear wins over a coincident increment
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end else if (r_pready && r_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  // Read data is a live view of the selected slice, only during a clean read
  always_comb begin
    w_prdata = '0;
    if (r_pready && !r_err && !r_write) begin
      for (int unsigned i = 0; i < REGN; i++) begin
        if (r_index == IDXW'(i)) w_prdata = reg_rdata[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign PRDATA    = w_prdata;
  assign PREADY    = r_pready;
  assign PSLVERR   = r_pready & r_err;
  assign reg_wr_en = r_wr_en;
  assign reg_rd_en = r_rd_en;
  assign reg_wdata = r_wdata;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_apb_reg_dec.sv
// Directed bench for apb_reg_dec: a WAIT_CYCLES=2 instance and a zero-wait
// instance share one APB master; use_b steers PSEL and the observed outputs.
module tb_apb_reg_dec;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned RN = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0]    m_paddr = '0;
  logic             m_psel = 1'b0, m_penable = 1'b0, m_pwrite = 1'b0;
  logic [DW-1:0]    m_pwdata = '0;
  logic             use_b = 1'b0;
  logic             err_clr = 1'b0;
  logic [RN*DW-1:0] rdata_bus = '0;

  logic [DW-1:0] a_prdata, b_prdata, s_prdata;
  logic          a_pready, b_pready, s_pready;
  logic          a_pslverr, b_pslverr, s_pslverr;
  logic [RN-1:0] a_wr, b_wr, s_wr, a_rd, b_rd, s_rd;
  logic [DW-1:0] a_wdata, b_wdata, s_wdata;
  logic [7:0]    a_ecnt, b_ecnt, s_ecnt;
  logic          a_psel, b_psel;

  assign a_psel    = m_psel & ~use_b;
  assign b_psel    = m_psel & use_b;
  assign s_prdata  = use_b ? b_prdata  : a_prdata;
  assign s_pready  = use_b ? b_pready  : a_pready;
  assign s_pslverr = use_b ? b_pslverr : a_pslverr;
  assign s_wr      = use_b ? b_wr      : a_wr;
  assign s_rd      = use_b ? b_rd      : a_rd;
  assign s_wdata   = use_b ? b_wdata   : a_wdata;
  assign s_ecnt    = use_b ? b_ecnt    : a_ecnt;

  apb_reg_dec #(.AWIDTH(AW), .DWIDTH(DW), .REGN(RN), .BASE(32'h40),
                .WAIT_CYCLES(2), .RO_MASK(8'h80)) u_dut_a (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(m_paddr), .PSEL(a_psel),
    .PENABLE(m_penable), .PWRITE(m_pwrite), .PWDATA(m_pwdata),
    .PRDATA(a_prdata), .PREADY(a_pready), .PSLVERR(a_pslverr),
    .reg_wr_en(a_wr), .reg_rd_en(a_rd), .reg_wdata(a_wdata),
    .reg_rdata(rdata_bus), .err_clr(err_clr), .err_cnt(a_ecnt));

  apb_reg_dec #(.AWIDTH(AW), .DWIDTH(DW), .REGN(RN), .BASE(32'h40),
                .WAIT_CYCLES(0), .RO_MASK(8'h80)) u_dut_b (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(m_paddr), .PSEL(b_psel),
    .PENABLE(m_penable), .PWRITE(m_pwrite), .PWDATA(m_pwdata),
    .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr),
    .reg_wr_en(b_wr), .reg_rd_en(b_rd), .reg_wdata(b_wdata),
    .reg_rdata(rdata_bus), .err_clr(err_clr), .err_cnt(b_ecnt));

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Results of the most recent transfer
  int          x_lat, x_rcyc, x_strb, x_stray;
  logic [31:0] x_rdat;
  logic        x_serr, x_leak;
  logic [7:0]  x_wr, x_rd;

  task automatic xfer(input logic [7:0] addr, input logic wr, input logic [31:0] wd,
                      input logic clr);
    @(posedge clk); #1;
    err_clr = 1'b0; m_psel = 1'b1; m_penable = 1'b0;
    m_paddr = addr; m_pwrite = wr; m_pwdata = wd;
    @(negedge clk);
    x_lat = -1; x_rcyc = -1; x_rdat = '0; x_serr = 1'b0; x_wr = '0; x_rd = '0;
    x_strb = ((s_wr != 0) || (s_rd != 0)) ? 1 : 0;
    x_leak = s_pready | s_pslverr | (s_prdata != 0);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      m_penable = 1'b1;
      @(negedge clk);
      if ((s_wr != 0) || (s_rd != 0)) x_strb++;
      if (s_pready) begin
        x_lat = k; x_rcyc = cyc; x_rdat = s_prdata; x_serr = s_pslverr;
        x_wr = s_wr; x_rd = s_rd;
        if (clr) err_clr = 1'b1;
        break;
      end
      if (s_pslverr || (s_prdata != 0)) x_leak = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      err_clr = 1'b0; m_psel = 1'b0; m_penable = 1'b0;
      @(negedge clk);
      if (s_pready || (s_wr != 0) || (s_rd != 0)) x_stray++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r1, r2;
    for (int i = 0; i < int'(RN); i++) rdata_bus[i*DW +: DW] = 32'h5A5A_0000 | 32'(i);
    rdata_bus[7*DW +: DW] = 32'h0000_1234;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_pready",  32'(a_pready),  32'h0);
    chk("rst_pslverr", 32'(a_pslverr), 32'h0);
    chk("rst_prdata",  a_prdata,       32'h0);
    chk("rst_wr_en",   32'(a_wr),      32'h0);
    chk("rst_rd_en",   32'(a_rd),      32'h0);
    chk("rst_wdata",   a_wdata,        32'h0);
    chk("rst_err_cnt", 32'(a_ecnt),    32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Write 0x48 -> register 2
    xfer(8'h48, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("wr48_lat",   32'(x_lat),  32'd3);
    chk("wr48_wr_en", 32'(x_wr),   32'h04);
    chk("wr48_rd_en", 32'(x_rd),   32'h00);
    chk("wr48_nstrb", 32'(x_strb), 32'd1);
    chk("wr48_serr",  32'(x_serr), 32'h0);
    chk("wr48_rdat",  x_rdat,      32'h0);
    chk("wr48_wdata", a_wdata,     32'hDEAD_BEEF);
    x_stray = 0;
    idle(1);
    chk("wr48_after", 32'(x_stray), 32'd0);

    // Reads: register 7 and register 1
    xfer(8'h5C, 1'b0, 32'h0, 1'b0);
    chk("rd5c_lat",   32'(x_lat),  32'd3);
    chk("rd5c_rdat",  x_rdat,      32'h0000_1234);
    chk("rd5c_rd_en", 32'(x_rd),   32'h80);
    chk("rd5c_wr_en", 32'(x_wr),   32'h00);
    chk("rd5c_serr",  32'(x_serr), 32'h0);
    chk("rd5c_nstrb", 32'(x_strb), 32'd1);
    xfer(8'h44, 1'b0, 32'h0, 1'b0);
    chk("rd44_rdat",  x_rdat,      32'h5A5A_0001);
    chk("rd44_rd_en", 32'(x_rd),   32'h02);

    // Write to the read-only register 7
    xfer(8'h5C, 1'b1, 32'h1111_1111, 1'b0);
    chk("wr5c_lat",   32'(x_lat),  32'd3);
    chk("wr5c_serr",  32'(x_serr), 32'h1);
    chk("wr5c_nstrb", 32'(x_strb), 32'd0);
    chk("wr5c_rdat",  x_rdat,      32'h0);
    idle(1);
    chk("wr5c_ecnt",  32'(a_ecnt), 32'd1);

    // Below base, misaligned, past the last register
    xfer(8'h3C, 1'b0, 32'h0, 1'b0);
    chk("rd3c_serr",  32'(x_serr), 32'h1);
    chk("rd3c_nstrb", 32'(x_strb), 32'd0);
    chk("rd3c_leak",  32'(x_leak), 32'h0);
    chk("rd3c_rdat",  x_rdat,      32'h0);
    xfer(8'h42, 1'b0, 32'h0, 1'b0);
    chk("rd42_serr",  32'(x_serr), 32'h1);
    chk("rd42_nstrb", 32'(x_strb), 32'd0);
    chk("rd42_rdat",  x_rdat,      32'h0);
    xfer(8'h60, 1'b1, 32'h2222_2222, 1'b0);
    chk("wr60_serr",  32'(x_serr), 32'h1);
    chk("wr60_nstrb", 32'(x_strb), 32'd0);
    idle(1);
    chk("bad_ecnt",   32'(a_ecnt), 32'd4);

    // Clear, then saturate with 300 errors
    @(posedge clk); #1;
    err_clr = 1'b1;
    idle(1);
    chk("clr_ecnt", 32'(a_ecnt), 32'd0);
    for (int k = 0; k < 300; k++) xfer(8'h60, 1'b0, 32'h0, 1'b0);
    idle(1);
    chk("sat_ecnt", 32'(a_ecnt), 32'd255);

    // Clear coincident with an error response
    xfer(8'h60, 1'b0, 32'h0, 1'b1);
    chk("clrrsp_serr", 32'(x_serr), 32'h1);
    idle(1);
    chk("clrrsp_ecnt", 32'(a_ecnt), 32'd0);

    // Abort during WAIT (erroring write, so a stray count would show)
    @(posedge clk); #1;
    m_psel = 1'b1; m_penable = 1'b0; m_paddr = 8'h5C; m_pwrite = 1'b1; m_pwdata = 32'h3333_3333;
    @(posedge clk); #1;
    m_psel = 1'b0; m_penable = 1'b0;
    x_stray = 0;
    idle(5);
    chk("abort_stray", 32'(x_stray), 32'd0);
    chk("abort_ecnt",  32'(a_ecnt),  32'd0);
    xfer(8'h40, 1'b1, 32'hA5A5_0040, 1'b0);
    chk("post_abort_lat",  32'(x_lat),  32'd3);
    chk("post_abort_wr",   32'(x_wr),   32'h01);
    chk("post_abort_serr", 32'(x_serr), 32'h0);

    // Back-to-back write 0x40, read 0x44
    xfer(8'h40, 1'b1, 32'h0000_0040, 1'b0);
    r1 = x_rcyc;
    xfer(8'h44, 1'b0, 32'h0, 1'b0);
    r2 = x_rcyc;
    chk("b2b_gap",  32'(r2 - r1), 32'd4);
    chk("b2b_rdat", x_rdat,       32'h5A5A_0001);
    chk("b2b_rd",   32'(x_rd),    32'h02);

    // Reset pulse during WAIT
    xfer(8'h5C, 1'b1, 32'h0, 1'b0);
    idle(1);
    chk("pre_rst_ecnt", 32'(a_ecnt), 32'd1);
    @(posedge clk); #1;
    m_psel = 1'b1; m_penable = 1'b0; m_paddr = 8'h48; m_pwrite = 1'b1; m_pwdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    m_penable = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_pready",  32'(a_pready),  32'h0);
    chk("mid_rst_pslverr", 32'(a_pslverr), 32'h0);
    chk("mid_rst_prdata",  a_prdata,       32'h0);
    chk("mid_rst_wr",      32'(a_wr),      32'h0);
    chk("mid_rst_rd",      32'(a_rd),      32'h0);
    chk("mid_rst_wdata",   a_wdata,        32'h0);
    chk("mid_rst_ecnt",    32'(a_ecnt),    32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Access-phase signals held after reset must be ignored in IDLE
    x_stray = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (a_pready || (a_wr != 0) || (a_rd != 0)) x_stray++;
      @(posedge clk); #1;
    end
    idle(2);
    chk("post_rst_stray", 32'(x_stray), 32'd0);
    chk("post_rst_wdata", a_wdata,      32'h0);

    // Zero-wait instance
    use_b = 1'b1;
    xfer(8'h4C, 1'b1, 32'h0BAD_F00D, 1'b0);
    r1 = x_rcyc;
    chk("b_wr_lat",   32'(x_lat),  32'd1);
    chk("b_wr_en",    32'(x_wr),   32'h08);
    chk("b_wr_nstrb", 32'(x_strb), 32'd1);
    chk("b_wr_wdata", s_wdata,     32'h0BAD_F00D);
    xfer(8'h50, 1'b0, 32'h0, 1'b0);
    r2 = x_rcyc;
    chk("b_rd_lat",   32'(x_lat),  32'd1);
    chk("b_rd_rdat",  x_rdat,      32'h5A5A_0004);
    chk("b_rd_en",    32'(x_rd),   32'h10);
    chk("b_b2b_gap",  32'(r2 - r1), 32'd2);
    x_stray = 0;
    idle(1);
    chk("b_after", 32'(x_stray), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
